fm7_keyboard: RTL and testbench

- Consumes the host key-event bus `ps2_key` (PS/2 set-2 events).
- Translates each event into FM-7 keyboard character codes and queues them in a small FIFO.
- Presents the head of the FIFO to the main CPU with a level interrupt; the CPU's read of the key-data port pops the entry.
- Sits inside `fm7`, between the `ps2_key` input and the main-CPU I/O decode for $FD00/$FD01.

---
 rtl/fm7_keyboard.sv | 200 ++++++++++++++++++++
 tb/tb_fm7_keyboard.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm7_keyboard.sv
`default_nettype none
// ============================================================================
// fm7_keyboard : PS/2 set-2 events -> FM-7 key codes, FIFO + level IRQ + repeat
// Revision 1.0
// ============================================================================
module fm7_keyboard #(
    parameter int FIFO_DEPTH   = 8,
    parameter int REPEAT_DELAY = 24000000,
    parameter int REPEAT_RATE  = 2400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        rd_ack,
    output logic [7:0]  key_data,
    output logic        key_irq,
    output logic [4:0]  key_count,
    output logic        caps_led,
    output logic        overflow
);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW     = $clog2(REP_MAX + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DECODE = 2'd1, S_PUSH = 2'd2} state_t;
    state_t state, state_nxt;

    logic          last_tog, armed;
    logic          ev_make, ev_ext;
    logic [7:0]    ev_code, xlat, xlat_comb;
    logic          shift_held, ctrl_held, caps;
    logic          rep_active;
    logic [8:0]    rep_scan;
    logic [7:0]    rep_code;
    logic [RCW-1:0] rep_cnt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic       event_det, is_mod, rep_stop, rep_fire, push, pop, full, wr_en;
    logic [7:0] push_data, letter;
    logic [4:0] digit;

    function automatic logic [7:0] letter_of(input logic [7:0] sc);
        case (sc)
            8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
            8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
            8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
            8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
            8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
            8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
            8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
            8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
            8'h35: return 8'h79;  8'h1A: return 8'h7A;
            default: return 8'h00;
        endcase
    endfunction

    // {valid, digit value}
    function automatic logic [4:0] digit_of(input logic [7:0] sc);
        case (sc)
            8'h45: return 5'h10;  8'h16: return 5'h11;  8'h1E: return 5'h12;
            8'h26: return 5'h13;  8'h25: return 5'h14;  8'h2E: return 5'h15;
            8'h36: return 5'h16;  8'h3D: return 5'h17;  8'h3E: return 5'h18;
            8'h46: return 5'h19;
            default: return 5'h00;
        endcase
    endfunction

    assign letter    = letter_of(ev_code);
    assign digit     = digit_of(ev_code);
    assign event_det = armed && (ps2_key[10] != last_tog);
    assign is_mod    = (ev_code == 8'h12) || (ev_code == 8'h59) ||
                       (ev_code == 8'h14) || (ev_code == 8'h58);

    always_comb begin
        xlat_comb = 8'h00;
        if (ev_ext) begin
            case (ev_code)
                8'h75:   xlat_comb = 8'h1E;
                8'h72:   xlat_comb = 8'h1F;
                8'h6B:   xlat_comb = 8'h1D;
                8'h74:   xlat_comb = 8'h1C;
                8'h5A:   xlat_comb = 8'h0D;
                default: xlat_comb = 8'h00;
            endcase
        end else if (letter != 8'h00) begin
            if (ctrl_held)               xlat_comb = letter & 8'h1F;
            else if (shift_held ^ caps)  xlat_comb = letter & 8'hDF;
            else                         xlat_comb = letter;
        end else if (digit[4]) begin
            // shifted 1..9 map onto the contiguous "!" .. ")" range; 0 is unchanged
            if (shift_held && digit[3:0] != 4'd0) xlat_comb = 8'h20 + {4'h0, digit[3:0]};
            else                                  xlat_comb = 8'h30 + {4'h0, digit[3:0]};
        end else begin
            case (ev_code)
                8'h5A:   xlat_comb = 8'h0D;
                8'h66:   xlat_comb = 8'h08;
                8'h29:   xlat_comb = 8'h20;
                8'h76:   xlat_comb = 8'h1B;
                default: xlat_comb = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (event_det) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (ev_make && !is_mod && xlat_comb != 8'h00) ? S_PUSH : S_IDLE;
            S_PUSH:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign rep_stop  = (state == S_DECODE) && !ev_make && ({ev_ext, ev_code} == rep_scan);
    assign rep_fire  = rep_active && (rep_cnt <= RCW'(1)) && (state != S_PUSH) && !rep_stop;
    assign push      = (state == S_PUSH) || rep_fire;
    assign push_data = (state == S_PUSH) ? xlat : rep_code;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = rd_ack && (count != '0);
    assign wr_en     = push && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            last_tog   <= 1'b0;
            armed      <= 1'b0;
            ev_make    <= 1'b0;
            ev_ext     <= 1'b0;
            ev_code    <= 8'h00;
            xlat       <= 8'h00;
            shift_held <= 1'b0;
            ctrl_held  <= 1'b0;
            caps       <= 1'b0;
            rep_active <= 1'b0;
            rep_scan   <= 9'h000;
            rep_code   <= 8'h00;
            rep_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            // tracks every toggle, so events arriving outside IDLE are lost for good
            last_tog <= ps2_key[10];
            armed    <= 1'b1;
            if (state == S_IDLE && event_det) begin
                ev_make <= ps2_key[9];
                ev_ext  <= ps2_key[8];
                ev_code <= ps2_key[7:0];
            end
            if (state == S_DECODE) begin
                xlat <= xlat_comb;
                if (ev_code == 8'h12 || ev_code == 8'h59) shift_held <= ev_make;
                if (ev_code == 8'h14)                     ctrl_held  <= ev_make;
                if (ev_code == 8'h58 && ev_make)          caps       <= ~caps;
            end
            if (state == S_PUSH) begin
                rep_active <= 1'b1;
                rep_scan   <= {ev_ext, ev_code};
                rep_code   <= xlat;
                rep_cnt    <= RCW'(REPEAT_DELAY);
            end else if (rep_stop) begin
                rep_active <= 1'b0;
            end else if (rep_active) begin
                rep_cnt <= (rep_cnt <= RCW'(1)) ? RCW'(REPEAT_RATE) : rep_cnt - RCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            key_data  <= 8'h00;
            key_irq   <= 1'b0;
            key_count <= 5'd0;
            caps_led  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
            key_data  <= (count != '0) ? mem[rd_ptr] : 8'h00;
            key_irq   <= (count != '0);
            key_count <= 5'(count);
            caps_led  <= caps;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fm7_keyboard.sv
`default_nettype none
// ============================================================================
// tb_fm7_keyboard : directed + randomized checks against a behavioural key model
// Revision 1.0
// ============================================================================
module tb_fm7_keyboard;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = 11'h400;
    logic        rd_ack = 1'b0;
    logic [7:0]  key_data;
    logic        key_irq;
    logic [4:0]  key_count;
    logic        caps_led;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    fm7_keyboard #(.FIFO_DEPTH(8), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .rd_ack(rd_ack),
        .key_data(key_data), .key_irq(key_irq), .key_count(key_count),
        .caps_led(caps_led), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [7:0] q[$];
    bit         m_ovf, m_shift, m_ctrl, m_caps;
    logic [7:0] lsc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dsc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    string      lower_s = "abcdefghijklmnopqrstuvwxyz";
    string      upper_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string      digit_s = "0123456789";
    string      shdig_s = "0!\"#$%&'()";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] model_xlat(input bit ex, input logic [7:0] sc);
        if (ex) begin
            case (sc)
                8'h75: return 8'h1E;  8'h72: return 8'h1F;  8'h6B: return 8'h1D;
                8'h74: return 8'h1C;  8'h5A: return 8'h0D;
                default: return 8'h00;
            endcase
        end
        for (int i = 0; i < 26; i++)
            if (lsc[i] == sc) begin
                if (m_ctrl)               return 8'(i + 1);
                else if (m_shift ^ m_caps) return upper_s[i];
                else                      return lower_s[i];
            end
        for (int i = 0; i < 10; i++)
            if (dsc[i] == sc) return m_shift ? shdig_s[i] : digit_s[i];
        case (sc)
            8'h5A: return 8'h0D;  8'h66: return 8'h08;
            8'h29: return 8'h20;  8'h76: return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_event(input bit mk, input bit ex, input logic [7:0] sc);
        logic [7:0] x;
        case (sc)
            8'h12, 8'h59: m_shift = mk;
            8'h14:        m_ctrl = mk;
            8'h58:        if (mk) m_caps = !m_caps;
            default: if (mk) begin
                x = model_xlat(ex, sc);
                if (x != 8'h00) begin
                    if (q.size() == 8) m_ovf = 1'b1;
                    else q.push_back(x);
                end
            end
        endcase
    endtask

    task automatic send(input bit mk, input bit ex, input logic [7:0] sc);
        @(negedge clk);
        ps2_key = {~ps2_key[10], mk, ex, sc};
    endtask

    task automatic ev(input bit mk, input bit ex, input logic [7:0] sc);
        send(mk, ex, sc);
        model_event(mk, ex, sc);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic tap(input bit ex, input logic [7:0] sc);
        ev(1'b1, ex, sc);
        ev(1'b0, ex, sc);
    endtask

    task automatic rd();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        m_ovf = 0; m_shift = 0; m_ctrl = 0; m_caps = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_count"}, 32'(key_count), 32'(q.size()));
        chk({tag, "_irq"},   32'(key_irq),   32'(q.size() != 0));
        chk({tag, "_data"},  32'(key_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
        chk({tag, "_caps"},  32'(caps_led),  32'(m_caps));
    endtask

    initial begin
        bit seen;
        int held_shift, held_ctrl;
        logic [7:0] keys [14] = '{8'h1C, 8'h32, 8'h1A, 8'h4D, 8'h16, 8'h45, 8'h3E,
                                  8'h5A, 8'h66, 8'h29, 8'h76, 8'h05, 8'h0E, 8'h1E};

        // reset state, and no spurious event on arming with ps2_key[10]=1
        repeat (2) @(posedge clk);
        #1;
        chk("reset_irq", 32'(key_irq), 0);
        chk("reset_count", 32'(key_count), 0);
        chk("reset_data", 32'(key_data), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (key_irq !== 1'b0 || key_count !== 5'd0) seen = 1;
        end
        chk("arm_no_event", 32'(seen), 0);

        // latency of a plain make
        send(1'b1, 1'b0, 8'h1C);
        repeat (3) @(posedge clk);
        #1;
        chk("lat_n2_irq", 32'(key_irq), 0);
        @(posedge clk);
        #1;
        chk("lat_n3_irq", 32'(key_irq), 1);
        chk("lat_n3_data", 32'(key_data), 32'h61);
        send(1'b0, 1'b0, 8'h1C);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("pop_irq", 32'(key_irq), 0);
        chk("pop_data", 32'(key_data), 0);

        // shift / ctrl ordering
        do_reset();
        ev(1, 0, 8'h12); tap(0, 8'h1C); ev(0, 0, 8'h12); tap(0, 8'h1C);
        ev(1, 0, 8'h14); tap(0, 8'h1C); ev(0, 0, 8'h14);
        chk("mod_count", 32'(key_count), 3);
        chk("mod_d0", 32'(key_data), 32'h41); rd();
        chk("mod_d1", 32'(key_data), 32'h61); rd();
        chk("mod_d2", 32'(key_data), 32'h01); rd();
        chk("mod_empty", 32'(key_count), 0);

        // caps lock
        tap(0, 8'h58);
        chk("caps_on", 32'(caps_led), 1);
        tap(0, 8'h1C);
        chk("caps_upper", 32'(key_data), 32'h41); rd();
        ev(1, 0, 8'h12); tap(0, 8'h1C); ev(0, 0, 8'h12);
        chk("caps_shift", 32'(key_data), 32'h61); rd();
        tap(0, 8'h58);
        chk("caps_off", 32'(caps_led), 0);

        // full FIFO, coincident pop, overflow
        do_reset();
        chk("rst2_ovf", 32'(overflow), 0);
        chk("rst2_count", 32'(key_count), 0);
        repeat (8) tap(0, 8'h5A);
        chk("full_count", 32'(key_count), 8);
        chk("full_ovf", 32'(overflow), 0);
        send(1'b1, 1'b0, 8'h5A);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        repeat (6) @(posedge clk);
        send(1'b0, 1'b0, 8'h5A);
        repeat (8) @(posedge clk);
        #1;
        chk("coinc_count", 32'(key_count), 8);
        chk("coinc_ovf", 32'(overflow), 0);
        tap(0, 8'h5A);
        chk("ovf_count", 32'(key_count), 8);
        chk("ovf_set", 32'(overflow), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_%0d", i), 32'(key_data), 32'h0D);
            rd();
        end
        chk("drain_count", 32'(key_count), 0);
        chk("drain_ovf_sticky", 32'(overflow), 1);

        // auto-repeat of an extended key
        do_reset();
        send(1'b1, 1'b1, 8'h75);
        for (int k = 0; k <= 33; k++) begin
            @(posedge clk);
            #1;
            case (k)
                2:  chk("rep_k2", 32'(key_count), 0);
                3:  begin chk("rep_k3", 32'(key_count), 1); chk("rep_k3_data", 32'(key_data), 32'h1E); end
                22: chk("rep_k22", 32'(key_count), 1);
                23: chk("rep_k23", 32'(key_count), 2);
                27: chk("rep_k27", 32'(key_count), 2);
                28: chk("rep_k28", 32'(key_count), 3);
                32: chk("rep_k32", 32'(key_count), 3);
                33: chk("rep_k33", 32'(key_count), 4);
                default: ;
            endcase
        end
        send(1'b0, 1'b1, 8'h75);
        repeat (40) @(posedge clk);
        #1;
        chk("rep_stopped", 32'(key_count), 4);

        // randomized traffic against the model
        do_reset();
        held_shift = 0;
        held_ctrl = 0;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0: begin ev(held_shift == 0, 0, 8'h12); held_shift = (held_shift == 0); end
                1: begin ev(held_ctrl == 0, 0, 8'h14); held_ctrl = (held_ctrl == 0); end
                2: tap(0, 8'h58);
                3, 4: rd();
                5: tap(1, ($urandom_range(0, 1) != 0) ? 8'h75 : (($urandom_range(0, 1) != 0) ? 8'h1C : 8'h5A));
                default: tap(0, keys[$urandom_range(0, 13)]);
            endcase
            check_model($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
